// File: rtl/bist_pkg.sv
// Shared command codes and FSM state encoding for the BIST sequencer.
package bist_pkg;

  localparam logic [7:0] CMD_NOP        = 8'hFF;
  localparam logic [7:0] CMD_END        = 8'h00;
  localparam logic [7:0] CMD_LOGIC_BASE = 8'h10;
  localparam logic [7:0] CMD_RESULT     = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_RUN,
    ST_READ,
    ST_FINISH
  } bist_state_e;

endpackage

// File: rtl/bist_downcounter.sv
// Loadable down-counter shared by the RUN and READ phases; saturates at zero.
module bist_downcounter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bist_sequencer.sv
// Moore FSM driving the BIST command bus: runs each enabled logic block,
// reads its verdict, records pass/fail and closes the session with 0x00.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int RUN_CYCLES  = 256,
  parameter int RES_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] blk_mask,
  input  logic        res_valid,
  input  logic        res_pass,
  output logic [7:0]  cmd_out,
  output logic [3:0]  cur_blk,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_mask,
  output logic [15:0] fail_mask,
  output logic        timeout_err,
  output logic        aborted
);

  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(RES_TIMEOUT - 1);

  bist_state_e      state;
  logic [15:0]      mask_lat;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             last_blk;

  assign last_blk = (cur_blk == 4'hF);

  bist_downcounter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // Counter control: reload on RUN/READ entry, count down while in them.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_SEARCH: begin
        if (mask_lat[cur_blk]) begin
          cnt_load = 1'b1;
          cnt_val  = RUN_LOAD;
        end
      end
      ST_RUN: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = TO_LOAD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_READ: cnt_en = 1'b1;
      default: ;
    endcase
  end

  // Session FSM; abort in any busy state wins over verdicts and freezes masks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_blk     <= 4'h0;
      mask_lat    <= '0;
      pass_mask   <= '0;
      fail_mask   <= '0;
      timeout_err <= 1'b0;
      aborted     <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            mask_lat    <= blk_mask;
            pass_mask   <= '0;
            fail_mask   <= '0;
            timeout_err <= 1'b0;
            aborted     <= 1'b0;
            done        <= 1'b0;
            cur_blk     <= 4'h0;
            state       <= (blk_mask == '0) ? ST_FINISH : ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_FINISH;
          end else if (mask_lat[cur_blk]) begin
            state <= ST_RUN;
          end else if (last_blk) begin
            state <= ST_FINISH;
          end else begin
            cur_blk <= cur_blk + 4'h1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_FINISH;
          end else if (cnt_zero) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_FINISH;
          end else if (res_valid || cnt_zero) begin
            if (res_valid) begin
              pass_mask[cur_blk] <= res_pass;
              fail_mask[cur_blk] <= ~res_pass;
            end else begin
              fail_mask[cur_blk] <= 1'b1;
              timeout_err        <= 1'b1;
            end
            if (last_blk) begin
              state <= ST_FINISH;
            end else begin
              cur_blk <= cur_blk + 4'h1;
              state   <= ST_SEARCH;
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Command bus and busy decode directly from the registered state.
  always_comb begin
    case (state)
      ST_RUN:    cmd_out = CMD_LOGIC_BASE | {4'h0, cur_blk};
      ST_READ:   cmd_out = CMD_RESULT;
      ST_FINISH: cmd_out = CMD_END;
      default:   cmd_out = CMD_NOP;
    endcase
    busy = (state != ST_IDLE);
  end

endmodule
